// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_pkg
// Purpose  : Shared widths and types for the PE / MAC / partial-sum drain
//            datapath, plus the group state encoding used by psum_drain.
// Contents : DATA_IN_W - PE operand width
//            PSUM_W    - partial-sum width leaving a PE column
//            ACC_W     - drain accumulator / result width
//            psum_t    - signed partial sum
//            acc_t     - signed accumulated result
//            drain_state_e - IDLE (no group open) / ACCUM (group open)
// Revision : 1.0 - initial release
// ============================================================================
package mac_pkg;

  localparam int DATA_IN_W = 8;
  localparam int PSUM_W    = 16;
  localparam int ACC_W     = 24;

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  // ST_IDLE  : Count == 0, next accepted sample opens a new group
  // ST_ACCUM : Count != 0, a group is partially accumulated
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } drain_state_e;

endpackage : mac_pkg
`default_nettype wire

// File: rtl/psum_fifo.sv
`default_nettype none
// ============================================================================
// Module   : psum_fifo
// Purpose  : Small circular result buffer for psum_drain. Each pointer carries
//            a round bit so full and empty are distinguishable when the
//            pointers coincide. The head entry is read combinationally.
// Ports    : clk       - clock, rising edge
//            rst       - synchronous active-high reset (flushes the buffer)
//            push      - write push_data at tail (ignored when full)
//            push_data - result to store
//            pop       - advance head (ignored when empty)
//            head_data - entry at head, combinational
//            full      - all BufferSize entries occupied
//            empty     - no entries occupied
// Revision : 1.0 - initial release
// ============================================================================
module psum_fifo #(
  parameter int AccWidth    = 24,
  parameter int BufferWidth = 2,
  parameter int BufferSize  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [AccWidth-1:0] push_data,
  input  logic                pop,
  output logic [AccWidth-1:0] head_data,
  output logic                full,
  output logic                empty
);

  // Pointer increment constant sized to {round, pointer}
  localparam logic [BufferWidth:0] PTR_ONE = {{BufferWidth{1'b0}}, 1'b1};

  logic [BufferWidth-1:0] head_q, head_d;
  logic [BufferWidth-1:0] tail_q, tail_d;
  logic                   head_rnd_q, head_rnd_d;
  logic                   tail_rnd_q, tail_rnd_d;
  logic [AccWidth-1:0]    mem_q [BufferSize];
  logic [AccWidth-1:0]    mem_d [BufferSize];

  logic do_push;
  logic do_pop;

  // Status decode: equal pointers mean either full or empty, the round bits
  // tell which.
  always_comb begin
    full    = (head_q == tail_q) && (head_rnd_q != tail_rnd_q);
    empty   = (head_q == tail_q) && (head_rnd_q == tail_rnd_q);
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Pointer and storage next-state. The round bit toggles exactly when the
  // pointer wraps, which falls out of incrementing {round, pointer} together.
  always_comb begin
    head_d     = head_q;
    head_rnd_d = head_rnd_q;
    tail_d     = tail_q;
    tail_rnd_d = tail_rnd_q;
    mem_d      = mem_q;

    if (do_push) begin
      mem_d[tail_q]        = push_data;
      {tail_rnd_d, tail_d} = {tail_rnd_q, tail_q} + PTR_ONE;
    end
    if (do_pop) begin
      {head_rnd_d, head_d} = {head_rnd_q, head_q} + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      head_rnd_q <= 1'b0;
      tail_q     <= '0;
      tail_rnd_q <= 1'b0;
      for (int i = 0; i < BufferSize; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      head_rnd_q <= head_rnd_d;
      tail_q     <= tail_d;
      tail_rnd_q <= tail_rnd_d;
      mem_q      <= mem_d;
    end
  end

  // Combinational head read: data is valid in the same cycle as !empty and
  // holds until the head advances.
  always_comb begin
    head_data = mem_q[head_q];
  end

endmodule : psum_fifo
`default_nettype wire

// File: rtl/psum_drain.sv
`default_nettype none
// ============================================================================
// Module   : psum_drain
// Purpose  : Consumer at the bottom of a PE column. Accumulates Cfg_Len
//            consecutive valid partial sums into one wide result, buffers
//            results in psum_fifo and hands them to write-back over a
//            valid/ready handshake. Back-pressures the column when the
//            buffer is full.
// Build    : define PSUM_DRAIN_RELU_EN to clamp negative results to zero
//            as they are written into the buffer (accumulator unaffected).
// Ports    : clk            - clock, rising edge
//            rst            - synchronous active-high reset
//            Cfg_Len        - partial sums per result, 0 behaves as 1
//            O_DataIn       - signed partial sum from the PE column
//            O_NOPIn        - bubble marker, O_DataIn ignored when high
//            O_DataInRdy    - drain can accept a partial sum
//            R_DataOut      - result at head of buffer
//            R_DataOutValid - buffer not empty
//            R_DataOutRdy   - write-back accepts R_DataOut
//            Busy           - a group is partially accumulated
// Revision : 1.0 - initial release
// ============================================================================
module psum_drain
  import mac_pkg::*;
#(
  parameter int DataInWidth = PSUM_W,
  parameter int AccWidth    = ACC_W,
  parameter int LenWidth    = 4,
  parameter int BufferWidth = 2,
  parameter int BufferSize  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LenWidth-1:0]    Cfg_Len,
  input  logic [DataInWidth-1:0] O_DataIn,
  input  logic                   O_NOPIn,
  output logic                   O_DataInRdy,
  output logic [AccWidth-1:0]    R_DataOut,
  output logic                   R_DataOutValid,
  input  logic                   R_DataOutRdy,
  output logic                   Busy
);

  localparam logic [LenWidth-1:0] LEN_ONE = {{(LenWidth-1){1'b0}}, 1'b1};

  drain_state_e          state_q, state_d;
  logic [AccWidth-1:0]   acc_q, acc_d;
  logic [LenWidth-1:0]   count_q, count_d;
  logic [LenWidth-1:0]   len_q, len_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  acc_hs;
  logic                  pop_hs;
  logic                  push;
  logic [AccWidth-1:0]   push_data;
  logic [AccWidth-1:0]   data_sext;
  logic [AccWidth-1:0]   sum;
  logic [LenWidth-1:0]   cfg_len_eff;
  logic [LenWidth-1:0]   eff_len;
  logic [LenWidth-1:0]   count_inc;
  logic                  last;

  // Handshake glue. Ready drops on full even for samples that would not
  // complete a group; this keeps the accept path free of the completion
  // decode. Held low during reset so nothing is accepted into a flushing
  // drain.
  always_comb begin
    O_DataInRdy    = !fifo_full && !rst;
    acc_hs         = !O_NOPIn && O_DataInRdy;
    R_DataOutValid = !fifo_empty;
    pop_hs         = R_DataOutValid && R_DataOutRdy;
    Busy           = (state_q == ST_ACCUM);
  end

  // Datapath: sign-extend and add with plain modular wrap.
  always_comb begin
    data_sext = {{(AccWidth-DataInWidth){O_DataIn[DataInWidth-1]}}, O_DataIn};
    sum       = acc_q + data_sext;
  end

  // Group length. The first sample of a group uses the live configuration
  // (and latches it); later samples use the latched copy so a mid-group
  // reconfiguration only affects the next group.
  always_comb begin
    cfg_len_eff = (Cfg_Len == '0) ? LEN_ONE : Cfg_Len;
    eff_len     = (state_q == ST_IDLE) ? cfg_len_eff : len_q;
    count_inc   = count_q + LEN_ONE;
    last        = (count_inc == eff_len);
  end

  // Group state machine and accumulator update. Bubbles leave everything
  // untouched.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    push    = 1'b0;

    if (acc_hs) begin
      if (state_q == ST_IDLE) begin
        len_d = cfg_len_eff;
      end
      if (last) begin
        push    = 1'b1;
        acc_d   = '0;
        count_d = '0;
        state_d = ST_IDLE;
      end else begin
        acc_d   = sum;
        count_d = count_inc;
        state_d = ST_ACCUM;
      end
    end
  end

  // Value written into the buffer on completion.
  always_comb begin
`ifdef PSUM_DRAIN_RELU_EN
    push_data = sum[AccWidth-1] ? '0 : sum;
`else
    push_data = sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
    end
  end

  // A completing sample is only accepted when ready, which already implies
  // the buffer is not full, so every push lands.
  psum_fifo #(
    .AccWidth    (AccWidth),
    .BufferWidth (BufferWidth),
    .BufferSize  (BufferSize)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop_hs),
    .head_data (R_DataOut),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule : psum_drain
`default_nettype wire
